activation_unit: RTL and testbench
==================================

# activation_unit

Post-accumulation activation stage for the FP32 neuron datapath. It sits directly downstream of the bias-adding accumulator and consumes one final FP32 neuron sum per `acc_valid` pulse. It applies the selected activation function using exponent and sign manipulation only, with no FPU instance, and buffers results in a first-word-fall-through FIFO. The next layer's input loader drains that FIFO through a valid/ready handshake.

## Interface

**Parameters**
- `DEPTH`, default 8: number of FIFO entries; must be a power of two, 2 or more.
- `LEAK_SHIFT`, default 3: leaky-ReLU negative slope is 2^-LEAK_SHIFT; legal range 1–126.

**Ports** (clock and reset first)
- `clk`, input, 1: clock; all logic is on the rising edge.
- `rstn`, input, 1: reset; synchronous, active-low.
- `flush`, input, 1: synchronous clear of the pipeline, FIFO and `overflow`.
- `acc_valid`, input, 1: one-cycle pulse marking that `acc_data` is a final neuron sum.
- `acc_data`, input, 32: IEEE-754 single-precision neuron sum.
- `act_sel`, input, 2: activation select, sampled with `acc_valid`. Encodings: 00 identity, 01 ReLU, 10 leaky ReLU, 11 clamp to [-1, 1].
- `out_valid`, output, 1: FIFO head is valid.
- `out_ready`, input, 1: consumer accepts the head.
- `out_data`, output, 32: FIFO head.
- `count`, output, clog2(DEPTH)+1: current FIFO occupancy.
- `fifo_full`, output, 1: `count` == DEPTH.
- `overflow`, output, 1: sticky flag; set when a result is dropped.

## Operation

**Pipeline**
- Stage 1 registers `acc_data`, `act_sel` and `acc_valid`.
- Stage 2 registers the activation result and its valid bit.
- The stage 2 valid bit writes the FIFO.
- The pipeline never stalls.

**Input classification**, with e = bits[30:23], m = bits[22:0], s = bit 31:
- NaN (e=255, m≠0): result is 0x7FC00000 in every mode.
- Denormal (e=0, m≠0): treated as signed zero.

**Modes**
- Identity: passes the value unchanged, except that denormals flush to {s, 31'b0}.
- ReLU: if s=1 (including -0, -inf and negative denormals) the result is 0x00000000; otherwise the input is passed, with denormals flushed to +0.
- Leaky ReLU:
  - Non-negative inputs behave as in ReLU.
  - Negative normal input with e > LEAK_SHIFT: result is {1, e-LEAK_SHIFT, m}.
  - Negative input with e ≤ LEAK_SHIFT, or negative denormal: result is 0x80000000.
  - -inf is passed unchanged.
- Clamp:
  - e ≥ 127 (|x| ≥ 1.0, including ±inf): result is {s, 0x3F800000[30:0]}, i.e. ±1.0.
  - Otherwise the input is passed, with denormals flushed to {s, 31'b0}.

**FIFO**
- First-word-fall-through: `out_data` shows the head whenever `out_valid`=1.
- A pop occurs when `out_valid` && `out_ready`.
- Pointers wrap modulo DEPTH.
- A write while full is accepted only if a pop occurs in the same cycle. Otherwise the result is dropped and `overflow` is set; `overflow` holds until flush or reset.
- Simultaneous push and pop when empty: the push is stored and the pop is ignored, because `out_valid` was 0.
- Simultaneous push and pop in any other state: `count` is unchanged.

**Reset and flush**
- Reset takes priority over flush.
- Both clear the stage valids, the pointers, `count`, `out_valid`, `fifo_full` and `overflow` to 0.
- `out_data` resets to 0x00000000.
- A reset or flush asserted mid-operation discards in-flight results. An `acc_valid` in the same cycle as reset or flush is lost.

## Timing

**Latency**
- `acc_valid` sampled at edge E gives stage 1 at E, stage 2 at E+1, and the FIFO write at E+2.
- With the FIFO empty, `out_valid`=1 and `out_data` holds the result in the cycle after edge E+2.

**Throughput**
- One result per cycle is accepted.
- Back-to-back `acc_valid` pulses are legal.

**Handshake**
- `out_data` and `out_valid` are stable while `out_valid`=1 and `out_ready`=0.
- `count` and `fifo_full` update on the edge of the push or pop.

## Test plan

- **ReLU:** `act_sel`=01 with sums 0x40400000 then 0xC0400000 (+3.0, -3.0) → outputs 0x40400000, 0x00000000 in order, 3-cycle latency.
- **Leaky ReLU and clamp:** `act_sel`=10 with LEAK_SHIFT=3 and 0xC0400000 (-3.0) → 0xBEC00000 (-0.375). `act_sel`=11 with 0x40400000 → 0x3F800000; with 0xBF000000 (-0.5) → 0xBF000000.
- **Special values:** 0x7F800001 in any mode → 0x7FC00000. 0x80000001 in identity → 0x80000000. 0xFF800000 in ReLU → 0x00000000.
- **Overflow:** `out_ready`=0 with DEPTH+1 (9) consecutive pulses of values 1..9 → `count`=8, `fifo_full`=1, `overflow`=1. Then `out_ready`=1 → values 1..8 drain in order and value 9 is absent.
- **Full with simultaneous pop:** FIFO full, push and pop in the same edge → `count` stays 8, no overflow, and the wrap-around order is preserved.
- **Mid-operation reset and flush:** pulse `rstn`=0 for one cycle with 3 entries queued and 1 in flight → next cycle `count`=0, `out_valid`=0, `overflow`=0, and no late write appears. Repeat using `flush`; the result is identical.

Source files
------------

// File: rtl/activation_unit.sv
// activation_unit: post-accumulation activation stage for the FP32 neuron datapath.
// Applies identity / ReLU / leaky ReLU / clamp using only sign and exponent
// manipulation, then queues results in a first-word-fall-through FIFO that the
// next layer drains with a valid/ready handshake.
module activation_unit #(
   parameter int DEPTH      = 8,
   parameter int LEAK_SHIFT = 3
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     flush,
   input  logic                     acc_valid,
   input  logic [31:0]              acc_data,
   input  logic [1:0]               act_sel,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     fifo_full,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0]  SEL_IDENT = 2'b00;
   localparam logic [1:0]  SEL_RELU  = 2'b01;
   localparam logic [1:0]  SEL_LEAKY = 2'b10;
   localparam logic [1:0]  SEL_CLAMP = 2'b11;

   localparam logic [31:0] QNAN      = 32'h7FC0_0000;
   localparam logic [31:0] ONE       = 32'h3F80_0000;
   localparam logic [7:0]  LEAK_E    = 8'(LEAK_SHIFT);
   localparam logic [7:0]  E_ONE     = 8'd127;
   localparam logic [7:0]  E_MAX     = 8'd255;

   // pipeline registers
   logic          s1_valid;
   logic [31:0]   s1_data;
   logic [1:0]    s1_sel;
   logic          s2_valid;
   logic [31:0]   s2_data;

   // FIFO storage and bookkeeping
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop;
   logic          push_ok;
   logic          push_drop;

   // field split of the stage 1 operand
   logic          in_s;
   logic [7:0]    in_e;
   logic [22:0]   in_m;
   logic          is_nan;
   logic          is_zero_like;
   logic [31:0]   signed_zero;
   logic [31:0]   act_result;

   assign in_s         = s1_data[31];
   assign in_e         = s1_data[30:23];
   assign in_m         = s1_data[22:0];
   assign is_nan       = (in_e == E_MAX) && (in_m != 23'd0);
   // zero and denormal are both handled as a signed zero
   assign is_zero_like = (in_e == 8'd0);
   assign signed_zero  = {in_s, 31'd0};

   // Stage 1: capture the accumulator sum and its mode select
   always_ff @(posedge clk) begin
      if (!rstn) begin
         s1_valid <= 1'b0;
         s1_data  <= 32'd0;
         s1_sel   <= 2'b00;
      end else if (flush) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= acc_valid;
         if (acc_valid) begin
            s1_data <= acc_data;
            s1_sel  <= act_sel;
         end
      end
   end

   // Activation function on the stage 1 operand, bit manipulation only
   always_comb begin
      act_result = s1_data;
      if (is_nan) begin
         act_result = QNAN;
      end else begin
         unique case (s1_sel)
            SEL_IDENT: begin
               act_result = is_zero_like ? signed_zero : s1_data;
            end
            SEL_RELU: begin
               if (in_s || is_zero_like)
                  act_result = 32'd0;
               else
                  act_result = s1_data;
            end
            SEL_LEAKY: begin
               if (!in_s) begin
                  act_result = is_zero_like ? 32'd0 : s1_data;
               end else if (in_e == E_MAX) begin
                  // -inf scaled by a positive factor is still -inf
                  act_result = s1_data;
               end else if (in_e > LEAK_E) begin
                  // multiply by 2^-LEAK_SHIFT by lowering the exponent
                  act_result = {1'b1, in_e - LEAK_E, in_m};
               end else begin
                  // result would be denormal or below; flush to -0
                  act_result = 32'h8000_0000;
               end
            end
            SEL_CLAMP: begin
               if (in_e >= E_ONE)
                  act_result = {in_s, ONE[30:0]};
               else if (is_zero_like)
                  act_result = signed_zero;
               else
                  act_result = s1_data;
            end
            default: act_result = s1_data;
         endcase
      end
   end

   // Stage 2: register the activation result alongside its valid bit
   always_ff @(posedge clk) begin
      if (!rstn) begin
         s2_valid <= 1'b0;
         s2_data  <= 32'd0;
      end else if (flush) begin
         s2_valid <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid)
            s2_data <= act_result;
      end
   end

   // FIFO handshake decode; a full FIFO still takes a write when it pops in the same cycle
   assign out_valid = (count != CW'(0));
   assign fifo_full = (count == CW'(DEPTH));
   assign pop       = out_valid && out_ready;
   assign push_ok   = s2_valid && (!fifo_full || pop);
   assign push_drop = s2_valid && fifo_full && !pop;
   assign out_data  = out_valid ? mem[rd_ptr] : 32'd0;

   // FIFO storage write; storage itself needs no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (rstn && !flush && push_ok)
         mem[wr_ptr] <= s2_data;
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop)
            count <= count + CW'(1);
         else if (pop && !push_ok)
            count <= count - CW'(1);
         if (push_drop)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_activation_unit.sv
// Directed testbench for activation_unit (DEPTH=8, LEAK_SHIFT=3).
module tb_activation_unit;

   logic        clk;
   logic        rstn;
   logic        flush;
   logic        acc_valid;
   logic [31:0] acc_data;
   logic [1:0]  act_sel;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  count;
   logic        fifo_full;
   logic        overflow;

   int n_chk = 0;
   int n_bad = 0;

   activation_unit #(.DEPTH(8), .LEAK_SHIFT(3)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .acc_valid (acc_valid),
      .acc_data  (acc_data),
      .act_sel   (act_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .fifo_full (fifo_full),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d, input logic [1:0] sel);
      acc_valid = 1'b1;
      acc_data  = d;
      act_sel   = sel;
      tick();
      acc_valid = 1'b0;
   endtask

   // wait (bounded) for a head, compare it, then pop it
   task automatic pop_expect(input string tag, input logic [31:0] exp);
      for (int k = 0; k < 20 && !out_valid; k++) tick();
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk(tag, out_data, exp);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   typedef struct {
      logic [31:0] din;
      logic [1:0]  sel;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [18];

   initial begin
      rstn      = 1'b0;
      flush     = 1'b0;
      acc_valid = 1'b0;
      acc_data  = 32'd0;
      act_sel   = 2'b00;
      out_ready = 1'b0;
      tick();
      tick();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_full", 32'(fifo_full), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_data", out_data, 32'd0);
      rstn = 1'b1;
      tick();

      // ReLU back-to-back with 3-cycle latency
      acc_valid = 1'b1; acc_data = 32'h4040_0000; act_sel = 2'b01;
      tick();
      acc_data = 32'hC040_0000;
      chk("lat_e0", 32'(out_valid), 32'd0);
      tick();
      acc_valid = 1'b0;
      chk("lat_e1", 32'(out_valid), 32'd0);
      tick();
      chk("lat_e2_valid", 32'(out_valid), 32'd1);
      chk("lat_e2_data", out_data, 32'h4040_0000);
      pop_expect("relu_pos", 32'h4040_0000);
      pop_expect("relu_neg", 32'h0000_0000);
      chk("relu_empty", 32'(count), 32'd0);

      // directed single-value vectors
      vecs[0]  = '{32'hC040_0000, 2'b10, 32'hBEC0_0000};
      vecs[1]  = '{32'h4040_0000, 2'b11, 32'h3F80_0000};
      vecs[2]  = '{32'hBF00_0000, 2'b11, 32'hBF00_0000};
      vecs[3]  = '{32'h7F80_0001, 2'b00, 32'h7FC0_0000};
      vecs[4]  = '{32'h7F80_0001, 2'b01, 32'h7FC0_0000};
      vecs[5]  = '{32'h7F80_0001, 2'b10, 32'h7FC0_0000};
      vecs[6]  = '{32'hFF80_0001, 2'b11, 32'h7FC0_0000};
      vecs[7]  = '{32'h8000_0001, 2'b00, 32'h8000_0000};
      vecs[8]  = '{32'hFF80_0000, 2'b01, 32'h0000_0000};
      vecs[9]  = '{32'hFF80_0000, 2'b10, 32'hFF80_0000};
      vecs[10] = '{32'h0000_0001, 2'b01, 32'h0000_0000};
      vecs[11] = '{32'h8000_0001, 2'b10, 32'h8000_0000};
      vecs[12] = '{32'h8180_0000, 2'b10, 32'h8000_0000};
      vecs[13] = '{32'h8200_0000, 2'b10, 32'h8080_0000};
      vecs[14] = '{32'hFF80_0000, 2'b11, 32'hBF80_0000};
      vecs[15] = '{32'h7F80_0000, 2'b11, 32'h3F80_0000};
      vecs[16] = '{32'h1234_5678, 2'b00, 32'h1234_5678};
      vecs[17] = '{32'h3F00_0000, 2'b01, 32'h3F00_0000};
      for (int i = 0; i < 18; i++) begin
         push(vecs[i].din, vecs[i].sel);
         pop_expect($sformatf("vec%0d", i), vecs[i].exp);
      end

      // overflow: nine pushes into an 8-deep FIFO with the consumer stalled
      for (int i = 1; i <= 9; i++) push(32'h4000_0000 | 32'(i), 2'b00);
      tick(); tick();
      chk("ovf_count", 32'(count), 32'd8);
      chk("ovf_full", 32'(fifo_full), 32'd1);
      chk("ovf_flag", 32'(overflow), 32'd1);
      for (int i = 1; i <= 8; i++) pop_expect($sformatf("ovf_drain%0d", i), 32'h4000_0000 | 32'(i));
      chk("ovf_nine_absent", 32'(out_valid), 32'd0);
      chk("ovf_sticky", 32'(overflow), 32'd1);

      // full FIFO with push and pop on the same edge, pointers offset to force wrap
      flush = 1'b1; tick(); flush = 1'b0;
      chk("flush_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < 3; i++) push(32'h4100_0000 | 32'(i), 2'b00);
      for (int i = 0; i < 3; i++) pop_expect($sformatf("pre%0d", i), 32'h4100_0000 | 32'(i));
      for (int i = 0; i < 8; i++) push(32'h4200_0000 | 32'(i), 2'b00);
      tick(); tick();
      chk("sim_full", 32'(fifo_full), 32'd1);
      acc_valid = 1'b1; acc_data = 32'h4200_0008; act_sel = 2'b00;
      tick();
      acc_valid = 1'b0;
      tick();
      out_ready = 1'b1;
      chk("sim_head", out_data, 32'h4200_0000);
      tick();
      out_ready = 1'b0;
      chk("sim_count", 32'(count), 32'd8);
      chk("sim_ovf", 32'(overflow), 32'd0);
      for (int i = 1; i <= 8; i++) pop_expect($sformatf("sim_drain%0d", i), 32'h4200_0000 | 32'(i));
      chk("sim_empty", 32'(count), 32'd0);

      // mid-operation reset, then the same with flush
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 3; i++) push(32'h4300_0000 | 32'(i), 2'b01);
         tick(); tick();
         chk($sformatf("mid%0d_pre", pass), 32'(count), 32'd3);
         push(32'h4300_0003, 2'b01);
         if (pass == 0) rstn = 1'b0; else flush = 1'b1;
         tick();
         rstn = 1'b1; flush = 1'b0;
         chk($sformatf("mid%0d_count", pass), 32'(count), 32'd0);
         chk($sformatf("mid%0d_valid", pass), 32'(out_valid), 32'd0);
         chk($sformatf("mid%0d_ovf", pass), 32'(overflow), 32'd0);
         chk($sformatf("mid%0d_data", pass), out_data, 32'd0);
         tick(); tick(); tick(); tick();
         chk($sformatf("mid%0d_late", pass), 32'(count), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
